// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, the
// word-count field width, and the running-checksum helper.
package prog_loader_pkg;

    // Width of the little-endian word-count field at the head of a frame.
    localparam int WORD_COUNT_W = 16;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_e;

    // Fold one accepted byte into the running XOR checksum.
    function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                               input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (LEN0, LEN1, 4*N data bytes,
// XOR checksum), writes the assembled 32-bit words into instruction memory and
// holds the processor in reset until the frame has been verified.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rx_valid, rx_data   - byte-stream source
//   rx_ready            - loader accepts a byte this cycle
//   imem_we/addr/wdata  - instruction memory write port (one-cycle strobe)
//   cpu_rst             - processor reset, released only after a good load
//   done, error         - sticky load status
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [WORD_COUNT_W:0] IMEM_WORDS_W = (WORD_COUNT_W + 1)'(IMEM_WORDS);

    loader_state_e            state_r, state_nxt_s;
    logic [1:0]               byte_cnt_r, byte_cnt_nxt_s;
    logic [WORD_COUNT_W-1:0]  word_idx_r, word_idx_nxt_s;
    logic [WORD_COUNT_W-1:0]  len_r, len_nxt_s;
    logic [23:0]              word_buf_r, word_buf_nxt_s;
    logic [7:0]               csum_r, csum_nxt_s;
    logic                     we_nxt_s;
    logic [31:0]              addr_nxt_s, wdata_nxt_s;
    logic                     accept_s;
    logic                     ready_s;
    logic [WORD_COUNT_W-1:0]  len_full_s;

    logic                     imem_we_r, done_r, error_r, cpu_rst_r;
    logic [31:0]              imem_addr_r, imem_wdata_r;

    // Ready is a pure state decode, gated by rst so it is low throughout reset
    // and high on the very first cycle after rst falls.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                S_LEN0, S_LEN1, S_DATA, S_CSUM: ready_s = 1'b1;
                default:                        ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s   = rx_valid & ready_s;
    assign len_full_s = {rx_data, len_r[7:0]};

    // Next-state, datapath and write-port decode.
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        word_idx_nxt_s = word_idx_r;
        len_nxt_s      = len_r;
        word_buf_nxt_s = word_buf_r;
        csum_nxt_s     = csum_r;
        we_nxt_s       = 1'b0;
        addr_nxt_s     = imem_addr_r;
        wdata_nxt_s    = imem_wdata_r;

        case (state_r)
            S_LEN0: begin
                if (accept_s) begin
                    len_nxt_s   = {8'h00, rx_data};
                    csum_nxt_s  = csum_update(csum_r, rx_data);
                    state_nxt_s = S_LEN1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LEN1: begin
                if (accept_s) begin
                    len_nxt_s  = len_full_s;
                    csum_nxt_s = csum_update(csum_r, rx_data);
                    if (len_full_s == 16'd0) begin
                        state_nxt_s = S_CSUM;
                    end else if ({1'b0, len_full_s} > IMEM_WORDS_W) begin
                        state_nxt_s = S_ERR;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    csum_nxt_s     = csum_update(csum_r, rx_data);
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    case (byte_cnt_r)
                        2'd0: word_buf_nxt_s[7:0]   = rx_data;
                        2'd1: word_buf_nxt_s[15:8]  = rx_data;
                        2'd2: word_buf_nxt_s[23:16] = rx_data;
                        2'd3: begin
                            // Byte 3 completes the word; it goes straight to
                            // the registered write port, never to the buffer.
                            we_nxt_s       = 1'b1;
                            wdata_nxt_s    = {rx_data, word_buf_r};
                            addr_nxt_s     = {14'd0, word_idx_r, 2'b00};
                            word_idx_nxt_s = word_idx_r + 16'd1;
                            word_buf_nxt_s = 24'd0;
                        end
                        default: word_buf_nxt_s = 24'd0;
                    endcase
                    if ((byte_cnt_r == 2'd3) && (word_idx_r == (len_r - 16'd1))) begin
                        state_nxt_s = S_CSUM;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    if (rx_data == csum_r) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_ERR;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_DONE:  state_nxt_s = S_DONE;
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_ERR;
        endcase
    end

    // State register; status outputs are registered from the next state so
    // cpu_rst drops on the cycle right after the checksum byte is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_LEN0;
            byte_cnt_r   <= 2'd0;
            word_idx_r   <= 16'd0;
            len_r        <= 16'd0;
            word_buf_r   <= 24'd0;
            csum_r       <= 8'd0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'd0;
            imem_wdata_r <= 32'd0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_rst_r    <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            byte_cnt_r   <= byte_cnt_nxt_s;
            word_idx_r   <= word_idx_nxt_s;
            len_r        <= len_nxt_s;
            word_buf_r   <= word_buf_nxt_s;
            csum_r       <= csum_nxt_s;
            imem_we_r    <= we_nxt_s;
            imem_addr_r  <= addr_nxt_s;
            imem_wdata_r <= wdata_nxt_s;
            done_r       <= (state_nxt_s == S_DONE);
            error_r      <= (state_nxt_s == S_ERR);
            cpu_rst_r    <= (state_nxt_s != S_DONE);
        end
    end

    assign rx_ready   = ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign done       = done_r;
    assign error      = error_r;
    assign cpu_rst    = cpu_rst_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader. Each table row is a byte
// stream plus the hand-computed memory writes and final status it must give.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, cpu_rst, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int vectors_applied = 0;
    int miscompares = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    prog_loader #(.IMEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    typedef struct {
        logic [11:0][7:0] bytes;
        int               nbytes;
        int               gap;
        int               nwr;
        logic [1:0][31:0] wa;
        logic [1:0][31:0] wd;
        logic             done_e;
        logic             err_e;
        logic             cpu_rst_e;
        logic             ready_e;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            miscompares++;
            vectors_applied++;
            $display("FAIL accept_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // The known-good two-instruction stream; its XOR over 02,00,13,00,00,00,
    // 93,00,10,00 is 0x92.
    task automatic load_good(inout vec_t v, input logic [7:0] cs, input int gap);
        v.bytes  = {8'h00, cs, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h00,
                    8'h00, 8'h13, 8'h00, 8'h02};
        v.nbytes = 11;
        v.gap    = gap;
        v.nwr    = 2;
        v.wa     = {32'h0000_0004, 32'h0000_0000};
        v.wd     = {32'h0010_0093, 32'h0000_0013};
    endtask

    initial begin
        // 0: good stream
        load_good(vecs[0], 8'h92, 0);
        vecs[0].done_e = 1'b1; vecs[0].err_e = 1'b0; vecs[0].cpu_rst_e = 1'b0; vecs[0].ready_e = 1'b0;
        // 1: empty program
        vecs[1].bytes = '0; vecs[1].nbytes = 3; vecs[1].gap = 0; vecs[1].nwr = 0;
        vecs[1].wa = '0; vecs[1].wd = '0;
        vecs[1].done_e = 1'b1; vecs[1].err_e = 1'b0; vecs[1].cpu_rst_e = 1'b0; vecs[1].ready_e = 1'b0;
        // 2: length 257 > capacity -> error right after LEN1
        vecs[2].bytes = '0; vecs[2].bytes[0] = 8'h01; vecs[2].bytes[1] = 8'h01;
        vecs[2].nbytes = 2; vecs[2].gap = 0; vecs[2].nwr = 0; vecs[2].wa = '0; vecs[2].wd = '0;
        vecs[2].done_e = 1'b0; vecs[2].err_e = 1'b1; vecs[2].cpu_rst_e = 1'b1; vecs[2].ready_e = 1'b0;
        // 3: bad checksum, writes still happen
        load_good(vecs[3], 8'h83, 0);
        vecs[3].done_e = 1'b0; vecs[3].err_e = 1'b1; vecs[3].cpu_rst_e = 1'b1; vecs[3].ready_e = 1'b0;
        // 4: good stream with 3-cycle gaps
        load_good(vecs[4], 8'h92, 3);
        vecs[4].done_e = 1'b1; vecs[4].err_e = 1'b0; vecs[4].cpu_rst_e = 1'b0; vecs[4].ready_e = 1'b0;
        // 5: one word 0xDEADBEEF; XOR 01^00^EF^BE^AD^DE = 0x23
        vecs[5].bytes = '0;
        vecs[5].bytes[0] = 8'h01; vecs[5].bytes[1] = 8'h00; vecs[5].bytes[2] = 8'hEF;
        vecs[5].bytes[3] = 8'hBE; vecs[5].bytes[4] = 8'hAD; vecs[5].bytes[5] = 8'hDE;
        vecs[5].bytes[6] = 8'h23;
        vecs[5].nbytes = 7; vecs[5].gap = 0; vecs[5].nwr = 1;
        vecs[5].wa = {32'h0, 32'h0}; vecs[5].wd = {32'h0, 32'hDEAD_BEEF};
        vecs[5].done_e = 1'b1; vecs[5].err_e = 1'b0; vecs[5].cpu_rst_e = 1'b0; vecs[5].ready_e = 1'b0;

        // Reset values while rst is held, then ready on the first free cycle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            @(negedge clk);
            wr_addr_q.delete();
            wr_data_q.delete();
            for (int b = 0; b < vecs[v].nbytes; b++) begin
                if (b == vecs[v].nbytes - 1) begin
                    check($sformatf("v%0d_cpu_rst_before_cs", v), {31'd0, cpu_rst}, 32'd1);
                end
                send_byte(vecs[v].bytes[b]);
                if (b < vecs[v].nbytes - 1) begin
                    for (int g = 0; g < vecs[v].gap; g++) begin
                        @(negedge clk);
                        check($sformatf("v%0d_stall_ready", v), {31'd0, rx_ready}, 32'd1);
                        check($sformatf("v%0d_stall_done", v), {31'd0, done}, 32'd0);
                    end
                end
            end
            // One cycle after the last byte: status already settled.
            check($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, vecs[v].cpu_rst_e});
            check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].done_e});
            check($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, vecs[v].err_e});
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_ready", v), {31'd0, rx_ready}, {31'd0, vecs[v].ready_e});
            check($sformatf("v%0d_done_sticky", v), {31'd0, done}, {31'd0, vecs[v].done_e});
            check($sformatf("v%0d_nwr", v), wr_addr_q.size(), vecs[v].nwr);
            for (int w = 0; w < vecs[v].nwr && w < wr_addr_q.size(); w++) begin
                check($sformatf("v%0d_w%0d_addr", v, w), wr_addr_q[w], vecs[v].wa[w]);
                check($sformatf("v%0d_w%0d_data", v, w), wr_data_q[w], vecs[v].wd[w]);
            end
        end

        // Capacity boundary: N = 256 is legal, loader keeps accepting data.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        check("len256_error", {31'd0, error}, 32'd0);
        check("len256_ready", {31'd0, rx_ready}, 32'd1);

        // Reset mid-load after the 6th byte, then a full frame restarts at 0.
        do_reset();
        for (int b = 0; b < 6; b++) begin
            send_byte(vecs[0].bytes[b]);
        end
        do_reset();
        check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int b = 0; b < vecs[0].nbytes; b++) begin
            send_byte(vecs[0].bytes[b]);
        end
        repeat (3) @(negedge clk);
        check("midrst_nwr", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() > 0) begin
            check("midrst_first_addr", wr_addr_q[0], 32'h0000_0000);
            check("midrst_first_data", wr_data_q[0], 32'h0000_0013);
        end
        check("midrst_done", {31'd0, done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
